// File: rtl/rx_pad_scheduler_pkg.sv
// rx_pkg: shared constants and pad engine state encoding
// for the receive line-gap recovery block.
package rx_pkg;
  localparam int NUM_CH = 4;
  localparam logic [15:0] LINE_WORDS = 16'h0050;
  localparam logic [15:0] FRAME_WORDS = 16'h9600;
  localparam logic [19:0] WD_LIMIT = 20'h23500;
  localparam logic [11:0] PAD_VALUE = 12'h000;

  typedef enum logic [1:0] {
    IDLE,
    PAD,
    DONE
  } pad_state_e;
endpackage

// File: rtl/rx_pad_scheduler_if.sv
// rx_pad_scheduler_if: packet inputs from the collectors and
// the pad write port / status toward the channel memories.
interface rx_pad_scheduler_if;
  import rx_pkg::*;

  logic [NUM_CH-1:0]    pkt_start;
  logic [16*NUM_CH-1:0] pkt_add;
  logic [NUM_CH-1:0]    out_of_link;
  logic [NUM_CH-1:0]    pad_we;
  logic [15:0]          pad_add;
  logic [11:0]          pad_data;
  logic [NUM_CH-1:0]    pad_pending;
  logic                 pad_busy;
  logic [15:0]          lines_padded;

  modport master (
    output pkt_start, pkt_add, out_of_link,
    input  pad_we, pad_add, pad_data,
    input  pad_pending, pad_busy, lines_padded
  );

  modport slave (
    input  pkt_start, pkt_add, out_of_link,
    output pad_we, pad_add, pad_data,
    output pad_pending, pad_busy, lines_padded
  );
endinterface

// File: rtl/rx_pad_scheduler_watchdog.sv
// rx_pkt_watchdog: per-channel line watchdog, owns the idle
// counter, the pad request and the expected line base.
module rx_pkt_watchdog
  import rx_pkg::*;
#(
  parameter logic [19:0] WD_LIM = WD_LIMIT
) (
  input  logic        Cclk,
  input  logic        rst,
  input  logic        pkt_start_i,
  input  logic [15:0] pkt_add_i,
  input  logic        out_of_link_i,
  input  logic        done_i,
  input  logic        abort_i,
  output logic        req_o,
  output logic [15:0] exp_base_o
);
  logic [19:0] wd_cnt_q, wd_cnt_d;
  logic        req_q, req_d;
  logic [15:0] exp_base_q, exp_base_d;
  logic [16:0] sum;

  // next-state for counter, request and expected base
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (pkt_start_i || done_i)
      wd_cnt_d = '0;
    else if (wd_cnt_q != WD_LIM)
      wd_cnt_d = wd_cnt_q + 20'd1;

    req_d = req_q;
    if (wd_cnt_q == WD_LIM - 20'd1 &&
        exp_base_q != FRAME_WORDS)
      req_d = 1'b1;
    if (pkt_start_i || out_of_link_i ||
        done_i || abort_i)
      req_d = 1'b0;

    sum = {1'b0, pkt_add_i} + {1'b0, LINE_WORDS};
    exp_base_d = exp_base_q;
    if (out_of_link_i && exp_base_q == FRAME_WORDS)
      exp_base_d = '0;
    else if (pkt_start_i)
      exp_base_d = (sum > {1'b0, FRAME_WORDS}) ?
                   FRAME_WORDS : sum[15:0];
    else if (done_i)
      exp_base_d = exp_base_q + LINE_WORDS;
  end

  // channel state registers
  always_ff @(posedge Cclk or posedge rst) begin
    if (rst) begin
      wd_cnt_q   <= '0;
      req_q      <= 1'b0;
      exp_base_q <= '0;
    end else begin
      wd_cnt_q   <= wd_cnt_d;
      req_q      <= req_d;
      exp_base_q <= exp_base_d;
    end
  end

  assign req_o      = req_q;
  assign exp_base_o = exp_base_q;
endmodule

// File: rtl/rx_pad_scheduler.sv
// rx_pad_scheduler: per-channel watchdogs plus one shared
// round-robin zero-pad engine for missing receive lines.
module rx_pad_scheduler
  import rx_pkg::*;
#(
  parameter logic [19:0] WD_LIM = WD_LIMIT
) (
  input logic               Cclk,
  input logic               rst,
  rx_pad_scheduler_if.slave bus
);
  pad_state_e        state_q;
  logic [1:0]        gch_q, rr_q;
  logic [15:0]       base_q, cnt_q;
  logic [NUM_CH-1:0] pad_we_q;
  logic [15:0]       pad_add_q;
  logic [15:0]       lines_padded_q;

  logic [NUM_CH-1:0] req, done, abort;
  logic [15:0]       exp_base [NUM_CH];
  logic              gnt_vld, abort_hit;
  logic [1:0]        gnt_ch;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rx_pkt_watchdog #(.WD_LIM(WD_LIM)) u_wd (
      .Cclk          (Cclk),
      .rst           (rst),
      .pkt_start_i   (bus.pkt_start[i]),
      .pkt_add_i     (bus.pkt_add[16*i +: 16]),
      .out_of_link_i (bus.out_of_link[i]),
      .done_i        (done[i]),
      .abort_i       (abort[i]),
      .req_o         (req[i]),
      .exp_base_o    (exp_base[i])
    );
  end

  // round-robin pick, lowest offset from rr_q wins
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = rr_q;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req[rr_q + 2'(k)]) begin
        gnt_vld = 1'b1;
        gnt_ch  = rr_q + 2'(k);
      end
    end
  end

  // completion and abort strobes back to the granted channel
  always_comb begin
    abort_hit = (state_q == PAD) &&
                (bus.pkt_start[gch_q] ||
                 bus.out_of_link[gch_q]);
    done  = (state_q == DONE) ? (4'b0001 << gch_q) : '0;
    abort = abort_hit ? (4'b0001 << gch_q) : '0;
  end

  // pad engine FSM with registered write port
  always_ff @(posedge Cclk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      gch_q          <= '0;
      rr_q           <= '0;
      base_q         <= '0;
      cnt_q          <= '0;
      pad_we_q       <= '0;
      pad_add_q      <= '0;
      lines_padded_q <= '0;
    end else begin
      pad_we_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            gch_q   <= gnt_ch;
            base_q  <= exp_base[gnt_ch];
            cnt_q   <= '0;
            rr_q    <= gnt_ch + 2'd1;
            state_q <= PAD;
          end
        end
        PAD: begin
          if (abort_hit) begin
            state_q <= IDLE;
          end else begin
            pad_we_q  <= 4'b0001 << gch_q;
            pad_add_q <= base_q + cnt_q;
            cnt_q     <= cnt_q + 16'd1;
            if (cnt_q == LINE_WORDS - 16'd1)
              state_q <= DONE;
          end
        end
        DONE: begin
          if (lines_padded_q != 16'hFFFF)
            lines_padded_q <= lines_padded_q + 16'd1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pad_we       = pad_we_q;
  assign bus.pad_add      = pad_add_q;
  assign bus.pad_data     = PAD_VALUE;
  assign bus.pad_pending  = req;
  assign bus.pad_busy     = (state_q != IDLE);
  assign bus.lines_padded = lines_padded_q;
endmodule
